// File: rtl/rgb_fade_sequencer.sv
// Duty-value sequencer for the RGB mixer: forwards encoder values, or plays a stored palette as linear fades.
// Optional macro RGB_SEQ_LOOP_EN: loop the palette instead of stopping after the last entry.
module rgb_fade_sequencer #(
    parameter int DEPTH      = 4,
    parameter int HOLD_TICKS = 64,
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [7:0]    enc0_val,
    input  logic [7:0]    enc1_val,
    input  logic [7:0]    enc2_val,
    input  logic          store,
    input  logic          play,
    input  logic          step_tick,
    output logic [7:0]    duty0,
    output logic [7:0]    duty1,
    output logic [7:0]    duty2,
    output logic [1:0]    state,
    output logic [IW-1:0] entry,
    output logic          update
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FADE = 2'b01,
        HOLD = 2'b10,
        STOP = 2'b11
    } state_t;

    state_t        state_reg;
    logic [IW-1:0] entry_reg;
    logic [IW-1:0] wr_idx_reg;
    logic [7:0]    hold_cnt_reg;
    logic          update_reg;
    logic [7:0]    duty_reg [3];
    logic [23:0]   palette_reg [DEPTH];

    logic [7:0]    enc_val   [3];
    logic [7:0]    target    [3];
    logic [7:0]    step_val  [3];
    logic [7:0]    duty_next [3];
    logic [2:0]    at_target;
    logic [2:0]    changed;
    logic [23:0]   cur_target;
    logic          fade_step;

    assign enc_val[0] = enc0_val;
    assign enc_val[1] = enc1_val;
    assign enc_val[2] = enc2_val;

    assign cur_target = palette_reg[entry_reg];
    assign fade_step  = play && (state_reg == FADE) && step_tick;

    // Channel 0 (R) lives in the top byte of each palette word.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign target[gi]   = cur_target[23-8*gi -: 8];
            assign step_val[gi] = (duty_reg[gi] < target[gi]) ? duty_reg[gi] + 8'd1 :
                                  (duty_reg[gi] > target[gi]) ? duty_reg[gi] - 8'd1 :
                                                                duty_reg[gi];
            assign at_target[gi] = (step_val[gi] == target[gi]);
            // Play low always tracks the encoders, including the cycle that leaves a play state.
            assign duty_next[gi] = !play     ? enc_val[gi] :
                                   fade_step ? step_val[gi] :
                                               duty_reg[gi];
            assign changed[gi]   = (duty_next[gi] != duty_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                duty_reg[i] <= 8'd0;
            end
            update_reg <= 1'b0;
        end else if (ena) begin
            for (int i = 0; i < 3; i++) begin
                duty_reg[i] <= duty_next[i];
            end
            update_reg <= |changed;
        end else begin
            update_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            entry_reg    <= '0;
            hold_cnt_reg <= 8'd0;
        end else if (ena) begin
            if (!play) begin
                state_reg    <= IDLE;
                entry_reg    <= '0;
                hold_cnt_reg <= 8'd0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= FADE;
                        entry_reg <= '0;
                    end
                    FADE: begin
                        if (step_tick && (&at_target)) begin
                            state_reg    <= HOLD;
                            hold_cnt_reg <= 8'd0;
                        end
                    end
                    HOLD: begin
                        if (step_tick) begin
                            if (hold_cnt_reg == 8'(HOLD_TICKS - 1)) begin
                                hold_cnt_reg <= 8'd0;
                                if (entry_reg == IW'(DEPTH - 1)) begin
`ifdef RGB_SEQ_LOOP_EN
                                    entry_reg <= '0;
                                    state_reg <= FADE;
`else
                                    state_reg <= STOP;
`endif
                                end else begin
                                    entry_reg <= entry_reg + IW'(1);
                                    state_reg <= FADE;
                                end
                            end else begin
                                hold_cnt_reg <= hold_cnt_reg + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= STOP;
                    end
                endcase
            end
        end
    end

    // Palette write port; the fade reads the pre-write value in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                palette_reg[i] <= 24'd0;
            end
            wr_idx_reg <= '0;
        end else if (ena && store) begin
            palette_reg[wr_idx_reg] <= {enc0_val, enc1_val, enc2_val};
            wr_idx_reg              <= wr_idx_reg + IW'(1);
        end
    end

    assign duty0  = duty_reg[0];
    assign duty1  = duty_reg[1];
    assign duty2  = duty_reg[2];
    assign state  = state_reg;
    assign entry  = entry_reg;
    assign update = update_reg;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_rgb_fade_sequencer;

    localparam int DEPTH = 4;
    localparam int HT    = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] enc0_val, enc1_val, enc2_val;
    logic       store, play, step_tick;
    logic [7:0] duty0, duty1, duty2;
    logic [1:0] state;
    logic [1:0] entry;
    logic       update;

    int n_tests = 0;
    int n_fail  = 0;

    rgb_fade_sequencer #(.DEPTH(DEPTH), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .enc0_val(enc0_val), .enc1_val(enc1_val), .enc2_val(enc2_val),
        .store(store), .play(play), .step_tick(step_tick),
        .duty0(duty0), .duty1(duty1), .duty2(duty2),
        .state(state), .entry(entry), .update(update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 fading, 2 holding, 3 stopped.
    int m_duty [3];
    int m_pal  [DEPTH][3];
    int m_mode, m_entry, m_held, m_wr;
    int m_upd;
    int mt [3];
    int nd [3];
    int me [3];
    int arrived;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) m_duty[c] = 0;
            for (int e = 0; e < DEPTH; e++)
                for (int c = 0; c < 3; c++) m_pal[e][c] = 0;
            m_mode = 0; m_entry = 0; m_held = 0; m_wr = 0; m_upd = 0;
        end else if (!ena) begin
            m_upd = 0;
        end else begin
            me[0] = enc0_val; me[1] = enc1_val; me[2] = enc2_val;
            for (int c = 0; c < 3; c++) begin
                mt[c] = m_pal[m_entry][c];
                nd[c] = m_duty[c];
            end
            if (!play) begin
                for (int c = 0; c < 3; c++) nd[c] = me[c];
                m_mode = 0; m_entry = 0; m_held = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_entry = 0;
            end else if (m_mode == 1 && step_tick) begin
                arrived = 1;
                for (int c = 0; c < 3; c++) begin
                    if (nd[c] < mt[c]) nd[c] = nd[c] + 1;
                    else if (nd[c] > mt[c]) nd[c] = nd[c] - 1;
                    if (nd[c] != mt[c]) arrived = 0;
                end
                if (arrived != 0) begin
                    m_mode = 2; m_held = 0;
                end
            end else if (m_mode == 2 && step_tick) begin
                m_held = m_held + 1;
                if (m_held == HT) begin
                    m_held = 0;
                    if (m_entry < DEPTH - 1) begin
                        m_entry = m_entry + 1; m_mode = 1;
                    end else begin
`ifdef RGB_SEQ_LOOP_EN
                        m_entry = 0; m_mode = 1;
`else
                        m_mode = 3;
`endif
                    end
                end
            end
            m_upd = 0;
            for (int c = 0; c < 3; c++) begin
                if (nd[c] != m_duty[c]) m_upd = 1;
                m_duty[c] = nd[c];
            end
            if (store) begin
                for (int c = 0; c < 3; c++) m_pal[m_wr][c] = me[c];
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
    end

    int watch1 = 0;
    int d1_moved = 0;

    always @(negedge clk) begin
        check("duty0", duty0, m_duty[0]);
        check("duty1", duty1, m_duty[1]);
        check("duty2", duty2, m_duty[2]);
        check("state", state, m_mode);
        check("entry", entry, m_entry);
        check("update", update, m_upd);
        if (watch1 != 0 && duty1 != 8'd0) d1_moved = 1;
    end

    task automatic next();
        @(posedge clk);
        #2;
        store = 1'b0;
        step_tick = 1'b0;
    endtask

    task automatic tick();
        step_tick = 1'b1;
        next();
        next();
    endtask

    task automatic set_enc(input int r, input int g, input int b);
        enc0_val = 8'(r); enc1_val = 8'(g); enc2_val = 8'(b);
    endtask

    task automatic chk_duty(input string name, input int r, input int g, input int b);
        check({name, "_r"}, duty0, r);
        check({name, "_g"}, duty1, g);
        check({name, "_b"}, duty2, b);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; store = 1'b0; play = 1'b0; step_tick = 1'b0;
        set_enc(0, 0, 0);
        #12;
        chk_duty("reset", 0, 0, 0);
        check("reset_state", state, 0);
        check("reset_entry", entry, 0);
        check("reset_update", update, 0);

        @(posedge clk); #2;
        rst_n = 1'b1; ena = 1'b1;
        set_enc(10, 20, 30);
        next();
        chk_duty("idle_track", 10, 20, 30);
        check("idle_update_hi", update, 1);
        next();
        check("idle_update_lo", update, 0);

        rst_n = 1'b0;
        #1;
        chk_duty("async_rst", 0, 0, 0);
        check("async_rst_state", state, 0);
        #1;
        rst_n = 1'b1;

        // Store entry 0 on the same edge play rises; duties stay at zero.
        set_enc(255, 0, 128); store = 1'b1; play = 1'b1;
        next();
        check("play_start_state", state, 1);
        chk_duty("play_start", 0, 0, 0);
        store = 1'b1; next();
        set_enc(250, 3, 128); store = 1'b1; next();
        set_enc(250, 3, 130); store = 1'b1; next();

        watch1 = 1;
        repeat (254) tick();
        check("fade254_r", duty0, 254);
        check("fade254_state", state, 1);
        tick();
        chk_duty("fade255", 255, 0, 128);
        check("fade255_state", state, 2);
        watch1 = 0;
        check("duty1_stayed_zero", d1_moved, 0);

        repeat (3) tick();
        check("hold3_state", state, 2);
        check("hold3_entry", entry, 0);
        chk_duty("hold3", 255, 0, 128);
        tick();
        check("hold4_entry", entry, 1);
        check("hold4_state", state, 1);

        tick();
        check("zero_dist_state", state, 2);
        repeat (HT) tick();
        check("e2_entry", entry, 2);
        repeat (5) tick();
        check("e2_state", state, 2);
        chk_duty("e2", 250, 3, 128);
        repeat (HT) tick();
        check("e3_entry", entry, 3);
        repeat (2) tick();
        chk_duty("e3", 250, 3, 130);
        repeat (HT) tick();
`ifdef RGB_SEQ_LOOP_EN
        check("loop_entry", entry, 0);
        check("loop_state", state, 1);
`else
        check("stop_state", state, 3);
        repeat (3) tick();
        check("stop_hold_state", state, 3);
        chk_duty("stop_frozen", 250, 3, 130);
`endif
        set_enc(1, 2, 3); play = 1'b0;
        next();
        check("exit_state", state, 0);
        chk_duty("exit_track", 1, 2, 3);

        play = 1'b1;
        next();
        repeat (5) tick();
        chk_duty("midfade", 6, 0, 8);
        ena = 1'b0;
        repeat (10) tick();
        chk_duty("ena_frozen", 6, 0, 8);
        check("ena_frozen_state", state, 1);
        ena = 1'b1; set_enc(7, 7, 7); play = 1'b0;
        next();
        check("abort_state", state, 0);
        chk_duty("abort_track", 7, 7, 7);

        // Retarget the active entry from 200 to 50 while duty sits at 100.
        set_enc(100, 100, 100);
        next();
        set_enc(200, 100, 100); store = 1'b1; play = 1'b1;
        next();
        repeat (3) begin
            store = 1'b1;
            next();
        end
        set_enc(50, 100, 100); store = 1'b1;
        next();
        tick();
        chk_duty("retarget", 99, 100, 100);
        check("retarget_state", state, 1);

        play = 1'b0;
        next();
        next();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
